// File: rtl/pipelined_mod_addsub.sv
// pipelined_mod_addsub: two-stage W-bit modular add/sub built on a parallel-prefix adder.
// Defining MOD_ADDSUB_RANGE_CHECK_EN adds the out_err operand range flag.
module pipelined_mod_addsub #(
  parameter int W = 8,
  parameter int ARCH = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_op,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [W-1:0] in_m,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_r
`ifdef MOD_ADDSUB_RANGE_CHECK_EN
  ,
  output logic         out_err
`endif
);
  localparam int L = $clog2(W);
  logic         s1Valid;
  logic         s1Op;
  logic [W:0]   s1S;
  logic [W-1:0] s1M;
  logic         s1En;
  logic         s2En;
  logic [W:0]   sum1;
  logic [W+1:0] t;
  logic [W-1:0] addR;
  logic [W-1:0] subR;
  logic [W-1:0] r;
  // Carry-in is folded into bit 0's generate so the tree yields true carries directly.
  function automatic logic [W:0] prefixAdd(input logic [W-1:0] x, input logic [W-1:0] y, input logic cin);
    logic [W-1:0] g, p, pr, gn, pn, sm;
    int j;
    g = x & y;
    p = x ^ y;
    pr = p;
    g[0] = g[0] | (p[0] & cin);
    for (int l = 0; l < L; l++) begin
      gn = g;
      pn = pr;
      for (int i = 0; i < W; i++) begin
        j = (ARCH == 0) ? i - (1 << l) : ((((i >> l) & 1) != 0) ? ((i >> l) << l) - 1 : -1);
        if (j >= 0) begin
          gn[i] = g[i] | (pr[i] & g[j]);
          pn[i] = pr[i] & pr[j];
        end
      end
      g = gn;
      pr = pn;
    end
    sm[0] = p[0] ^ cin;
    for (int i = 1; i < W; i++) sm[i] = p[i] ^ g[i-1];
    return {g[W-1], sm};
  endfunction
  assign s2En = !out_valid || out_ready;
  assign s1En = !s1Valid || s2En;
  assign in_ready = s1En;
  always_comb begin
    sum1 = prefixAdd(in_a, in_op ? ~in_b : in_b, in_op);
    t = {1'b0, s1S} - {2'b0, s1M};
    addR = t[W+1] ? s1S[W-1:0] : t[W-1:0];
    subR = s1S[W] ? s1S[W-1:0] : s1S[W-1:0] + s1M;
    r = s1Op ? subR : addR;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid <= 1'b0;
      s1Op <= 1'b0;
      s1S <= '0;
      s1M <= '0;
    end else if (s1En) begin
      s1Valid <= in_valid;
      s1Op <= in_op;
      s1S <= sum1;
      s1M <= in_m;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_r <= '0;
    end else if (s2En) begin
      out_valid <= s1Valid;
      if (s1Valid) out_r <= r;
    end
  end
`ifdef MOD_ADDSUB_RANGE_CHECK_EN
  logic s1Err;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Err <= 1'b0;
      out_err <= 1'b0;
    end else begin
      if (s1En) s1Err <= (in_a >= in_m) || (in_b >= in_m) || (in_m < W'(2));
      if (s2En && s1Valid) out_err <= s1Err;
    end
  end
`endif
endmodule

// File: tb/tb_pipelined_mod_addsub.sv
// tb_pipelined_mod_addsub: checks Kogge-Stone and Sklansky builds side by side against a queue-based modular model.
module tb_pipelined_mod_addsub;
  localparam int W = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic inValid = 1'b0;
  logic inOp = 1'b0;
  logic outReady = 1'b1;
  logic [W-1:0] inA = '0;
  logic [W-1:0] inB = '0;
  logic [W-1:0] inM = 4'd2;
  logic rdy0, rdy1, ov0, ov1;
  logic [W-1:0] r0, r1;
`ifdef MOD_ADDSUB_RANGE_CHECK_EN
  logic e0, e1;
`endif
  int checks = 0;
  int errors = 0;
  int popped = 0;
  typedef struct {
    logic [W-1:0] r;
    logic e;
  } expT;
  expT q[$];
  logic prevStall = 1'b0;
  logic [W-1:0] prevR = '0;
  always #5 clk = ~clk;
  pipelined_mod_addsub #(.W(W), .ARCH(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(rdy0), .in_op(inOp),
    .in_a(inA), .in_b(inB), .in_m(inM), .out_valid(ov0), .out_ready(outReady), .out_r(r0)
`ifdef MOD_ADDSUB_RANGE_CHECK_EN
    , .out_err(e0)
`endif
  );
  pipelined_mod_addsub #(.W(W), .ARCH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(rdy1), .in_op(inOp),
    .in_a(inA), .in_b(inB), .in_m(inM), .out_valid(ov1), .out_ready(outReady), .out_r(r1)
`ifdef MOD_ADDSUB_RANGE_CHECK_EN
    , .out_err(e1)
`endif
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, req);
    end
  endtask
  function automatic expT model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] m);
    int ia, ib, im, s;
    expT x;
    ia = int'(a);
    ib = int'(b);
    im = int'(m);
    s = ia + ib;
    if (!op) x.r = W'(s >= im ? s - im : s);
    else x.r = W'(ia >= ib ? ia - ib : ia - ib + im);
    x.e = (ia >= im) || (ib >= im) || (im < 2);
    return x;
  endfunction
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      prevStall = 1'b0;
    end else begin
      expT x;
      chk("ready_arch1", rdy1, rdy0);
      chk("valid_arch1", ov1, ov0);
      if (prevStall) begin
        chk("hold_valid", ov0, 1);
        chk("hold_r", r0, prevR);
      end
      if (ov0 && outReady) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_out actual out_r=%0d required no result", r0);
        end else begin
          x = q.pop_front();
          chk("r_arch0", r0, x.r);
          chk("r_arch1", r1, x.r);
`ifdef MOD_ADDSUB_RANGE_CHECK_EN
          chk("err_arch0", e0, x.e);
          chk("err_arch1", e1, x.e);
`endif
          popped++;
        end
      end
      prevStall = ov0 && !outReady;
      prevR = r0;
      if (inValid && rdy0) q.push_back(model(inOp, inA, inB, inM));
    end
  end
  task automatic drive(input logic op, input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] m);
    inOp = op;
    inA = a;
    inB = b;
    inM = m;
  endtask
  task automatic single(input string name, input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] m, input logic [W-1:0] req);
    @(posedge clk);
    #1;
    outReady = 1'b1;
    inValid = 1'b1;
    drive(op, a, b, m);
    @(posedge clk);
    #1;
    inValid = 1'b0;
    chk({name, "_early"}, ov0, 0);
    @(posedge clk);
    #1;
    chk({name, "_valid"}, ov0, 1);
    chk({name, "_a0"}, r0, req);
    chk({name, "_a1"}, r1, req);
  endtask
  task automatic send(input logic op, input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] m);
    bit acc;
    acc = 1'b0;
    inValid = 1'b1;
    drive(op, a, b, m);
    for (int k = 0; k < 100; k++) begin
      outReady = 1'($urandom_range(0, 1));
      #2;
      acc = rdy0;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual in_ready=0 required 1 within 100 cycles");
    end
    inValid = 1'b0;
  endtask
  logic [15:0] vec [8] = '{16'h09_7d, 16'h0c_1d, 16'h05_6d, 16'h13_9d, 16'h19_3d, 16'h14_4d, 16'h01_12, 16'h10_12};
  initial begin
    int base, idx;
    bit acc;
    logic [15:0] v;
    logic [W-1:0] ms [3];
    ms[0] = 4'd2;
    ms[1] = 4'd13;
    ms[2] = 4'd15;
    #1;
    chk("rst_valid_a0", ov0, 0);
    chk("rst_r_a0", r0, 0);
    chk("rst_valid_a1", ov1, 0);
    chk("rst_r_a1", r1, 0);
    #11 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_release_ready", rdy0, 1);
    single("add_9_7", 1'b0, 4'd9, 4'd7, 4'd13, 4'd3);
    single("add_12_1", 1'b0, 4'd12, 4'd1, 4'd13, 4'd0);
    single("add_5_6", 1'b0, 4'd5, 4'd6, 4'd13, 4'd11);
    single("sub_3_9", 1'b1, 4'd3, 4'd9, 4'd13, 4'd7);
    single("sub_9_3", 1'b1, 4'd9, 4'd3, 4'd13, 4'd6);
    single("sub_4_4", 1'b1, 4'd4, 4'd4, 4'd13, 4'd0);
    single("sub_0_15_m15", 1'b1, 4'd0, 4'd15, 4'd15, 4'd0);
    single("add_m0", 1'b0, 4'd9, 4'd8, 4'd0, 4'd1);
    @(posedge clk);
    #1;
    inValid = 1'b1;
    drive(1'b0, 4'd9, 4'd7, 4'd13);
    @(posedge clk);
    #1;
    drive(1'b0, 4'd5, 4'd6, 4'd13);
    @(posedge clk);
    #1;
    chk("midrst_pre_r", r0, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid_a0", ov0, 0);
    chk("midrst_r_a0", r0, 0);
    chk("midrst_valid_a1", ov1, 0);
    chk("midrst_r_a1", r1, 0);
    inValid = 1'b0;
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_ready", rdy0, 1);
    chk("midrst_empty", ov0, 0);
    base = popped;
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      outReady = !(c >= 3 && c <= 5);
      inValid = idx < 8;
      if (idx < 8) begin
        v = vec[idx];
        drive(v[12], v[11:8], v[7:4], v[3:0]);
      end
      #2;
      if (c < 8) chk("stream_ready", rdy0, !(c >= 3 && c <= 5));
      acc = inValid && rdy0;
      @(posedge clk);
      #1;
      if (acc) idx++;
    end
    inValid = 1'b0;
    chk("stream_count", popped - base, 8);
    chk("stream_queue", q.size(), 0);
    base = popped;
    for (int mi = 0; mi < 3; mi++)
      for (int op = 0; op < 2; op++)
        for (int a = 0; a < int'(ms[mi]); a++)
          for (int b = 0; b < int'(ms[mi]); b++)
            send(1'(op), W'(a), W'(b), ms[mi]);
    outReady = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("exh_count", popped - base, 796);
    chk("exh_queue", q.size(), 0);
`ifdef MOD_ADDSUB_RANGE_CHECK_EN
    single("range_a14", 1'b0, 4'd14, 4'd1, 4'd13, 4'd2);
    chk("range_err_a0", e0, 1);
    chk("range_err_a1", e1, 1);
    single("range_legal", 1'b0, 4'd3, 4'd4, 4'd13, 4'd7);
    chk("legal_err_a0", e0, 0);
    chk("legal_err_a1", e1, 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog actual timeout required completion");
    $fatal(1, "watchdog");
  end
endmodule
